// File: rtl/apb_slave_mux.sv
// APB slave sequencer and response mux for the AHB-to-APB bridge.
// One request at a time: decode slave, run SETUP/ACCESS, return response.
//
// Ports:
//   Hclk, Hresetn          clock, async active-low reset
//   req_*                  request from bridge control (req_ready = IDLE)
//   resp_*                 registered response, resp_valid is a 1-cycle strobe
//   Paddr_s/Pwrite_s/...   APB master side shared by all slaves
//   Psel_s                 one-hot select, Prdata_s slave i at [i*DW +: DW]
module apb_slave_mux #(
    parameter int NSLV    = 4,
    parameter int DW      = 32,
    parameter int SEL_LSB = 8,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               Hclk,
    input  logic               Hresetn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [31:0]        req_addr,
    input  logic               req_write,
    input  logic [DW-1:0]      req_wdata,
    output logic               resp_valid,
    output logic [DW-1:0]      resp_rdata,
    output logic               resp_err,
    output logic               resp_timeout,
    output logic [31:0]        Paddr_s,
    output logic               Pwrite_s,
    output logic [DW-1:0]      Pwdata_s,
    output logic [NSLV-1:0]    Psel_s,
    output logic               Penable_s,
    input  logic [NSLV*DW-1:0] Prdata_s,
    input  logic [NSLV-1:0]    Pready_s,
    input  logic [NSLV-1:0]    Pslverr_s
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SEL_W:0] NSLV_L = (SEL_W + 1)'(NSLV);
    localparam logic [CW-1:0] CNT_LAST =
        (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [SEL_W-1:0] sel_idx;
    logic            mapped;
    logic [NSLV-1:0] hot;
    logic            sel_ready;
    logic            sel_err;
    logic [DW-1:0]   sel_rdata;

    assign req_ready = (state == IDLE);

    assign sel_idx = req_addr[SEL_LSB +: SEL_W];
    assign mapped  = {1'b0, sel_idx} < NSLV_L;

    always_comb begin
        hot = '0;
        for (int i = 0; i < NSLV; i++) begin
            hot[i] = ({1'b0, sel_idx} == (SEL_W + 1)'(i));
        end
    end

    // Psel_s is one-hot during SETUP/ACCESS and zero otherwise, so it
    // doubles as the mask that ignores every other slave's handshake.
    assign sel_ready = |(Pready_s & Psel_s);
    assign sel_err   = |(Pslverr_s & Psel_s);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            sel_rdata = sel_rdata | (Prdata_s[i*DW +: DW] & {DW{Psel_s[i]}});
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state        <= IDLE;
            cnt          <= '0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
            resp_timeout <= 1'b0;
            Paddr_s      <= '0;
            Pwrite_s     <= 1'b0;
            Pwdata_s     <= '0;
            Psel_s       <= '0;
            Penable_s    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        Paddr_s  <= req_addr;
                        Pwrite_s <= req_write;
                        Pwdata_s <= req_wdata;
                        if (mapped) begin
                            Psel_s <= hot;
                            state  <= SETUP;
                        end else begin
                            resp_valid   <= 1'b1;
                            resp_err     <= 1'b1;
                            resp_timeout <= 1'b0;
                            resp_rdata   <= '0;
                            state        <= RESP;
                        end
                    end
                end
                SETUP: begin
                    Penable_s <= 1'b1;
                    cnt       <= '0;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    // cnt holds completed ACCESS cycles, so cnt == TIMEOUT-1
                    // marks the TIMEOUT-th cycle; ready still wins there.
                    if (sel_ready) begin
                        resp_valid   <= 1'b1;
                        resp_err     <= sel_err;
                        resp_timeout <= 1'b0;
                        resp_rdata   <= (!Pwrite_s && !sel_err) ? sel_rdata : '0;
                        Psel_s       <= '0;
                        Penable_s    <= 1'b0;
                        state        <= RESP;
                    end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                        resp_valid   <= 1'b1;
                        resp_err     <= 1'b1;
                        resp_timeout <= 1'b1;
                        resp_rdata   <= '0;
                        Psel_s       <= '0;
                        Penable_s    <= 1'b0;
                        state        <= RESP;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_mux.sv
// Randomised self-checking bench for apb_slave_mux.
// Expected latency/response derive from slave wait count and index only.
module tb_apb_slave_mux;

    localparam int NSLV    = 4;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic               Hclk;
    logic               Hresetn;
    logic               req_valid;
    logic               req_ready;
    logic [31:0]        req_addr;
    logic               req_write;
    logic [DW-1:0]      req_wdata;
    logic               resp_valid;
    logic [DW-1:0]      resp_rdata;
    logic               resp_err;
    logic               resp_timeout;
    logic [31:0]        Paddr_s;
    logic               Pwrite_s;
    logic [DW-1:0]      Pwdata_s;
    logic [NSLV-1:0]    Psel_s;
    logic               Penable_s;
    logic [NSLV*DW-1:0] Prdata_s;
    logic [NSLV-1:0]    Pready_s;
    logic [NSLV-1:0]    Pslverr_s;

    int n_cmp;
    int n_bad;

    apb_slave_mux #(
        .NSLV(NSLV), .DW(DW), .SEL_LSB(8), .SEL_W(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .Hclk(Hclk), .Hresetn(Hresetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_timeout(resp_timeout),
        .Paddr_s(Paddr_s), .Pwrite_s(Pwrite_s), .Pwdata_s(Pwdata_s),
        .Psel_s(Psel_s), .Penable_s(Penable_s),
        .Prdata_s(Prdata_s), .Pready_s(Pready_s), .Pslverr_s(Pslverr_s)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic noise();
        Pready_s  = NSLV'($urandom);
        Pslverr_s = NSLV'($urandom);
    endtask

    // One transfer. Entry and exit at a negedge with the DUT idle.
    // w = slave wait states, ready on ACCESS cycle w+1.
    task automatic xfer(input logic [3:0] sidx, input logic wr,
                        input logic [31:0] wd, input int w,
                        input logic serr, input logic [31:0] force_rd);
        logic [31:0] addr;
        logic [31:0] rd [NSLV];
        logic        map;
        int          exp_lat;
        logic        exp_err;
        logic        exp_to;
        logic [31:0] exp_rd;
        int          lat;

        addr = $urandom;
        addr[11:8] = sidx;
        for (int i = 0; i < NSLV; i++) begin
            rd[i] = $urandom;
            if (i == int'(sidx) && force_rd != 0) rd[i] = force_rd;
            Prdata_s[i*DW +: DW] = rd[i];
        end
        map = (int'(sidx) < NSLV);

        if (!map) begin
            exp_lat = 1; exp_err = 1'b1; exp_to = 1'b0; exp_rd = '0;
        end else if (w < TIMEOUT) begin
            exp_lat = 3 + w; exp_err = serr; exp_to = 1'b0;
            exp_rd = (wr || serr) ? 32'h0 : rd[sidx];
        end else begin
            exp_lat = 2 + TIMEOUT; exp_err = 1'b1; exp_to = 1'b1;
            exp_rd = '0;
        end

        check("ready_pre", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_write = wr;
        req_wdata = wd;
        noise();

        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge Hclk);
            @(negedge Hclk);
            req_valid = 1'b0;
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_write = 1'($urandom);
            if (c == 1) begin
                check("setup_psel", Psel_s, map ? (64'd1 << sidx) : 64'd0);
                check("setup_pen", Penable_s, 0);
                check("paddr", Paddr_s, addr);
                check("pwrite", Pwrite_s, wr);
                check("pwdata", Pwdata_s, wd);
            end
            if (c == 2 && map) begin
                check("access_psel", Psel_s, 64'd1 << sidx);
                check("access_pen", Penable_s, 1);
            end
            if (resp_valid) begin
                lat = c;
                break;
            end
            noise();
            if (map && c >= 2) begin
                Pready_s[sidx]  = (c - 1 > w);
                Pslverr_s[sidx] = serr;
            end
        end

        check("latency", lat, exp_lat);
        check("resp_err", resp_err, exp_err);
        check("resp_to", resp_timeout, exp_to);
        check("resp_rdata", resp_rdata, exp_rd);
        check("resp_psel", {Penable_s, Psel_s}, 0);

        noise();
        @(posedge Hclk);
        @(negedge Hclk);
        check("post_ready", req_ready, 1);
        check("post_valid", resp_valid, 0);
        check("hold_rdata", resp_rdata, exp_rd);
        check("hold_err", {resp_err, resp_timeout}, {exp_err, exp_to});
        check("hold_pwdata", Pwdata_s, wd);
    endtask

    task automatic rst_mid();
        logic [31:0] a;
        a = 32'h0000_0100;
        req_valid = 1'b1;
        req_addr  = a;
        req_write = 1'b0;
        Pready_s  = '0;
        @(posedge Hclk);
        @(negedge Hclk);
        req_valid = 1'b0;
        Pready_s  = '0;
        repeat (3) @(negedge Hclk);
        check("mid_pen", Penable_s, 1);
        #2 Hresetn = 1'b0;
        #1;
        check("rst_psel", Psel_s, 0);
        check("rst_pen", Penable_s, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_ready", req_ready, 1);
        @(negedge Hclk);
        Hresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            Pready_s = '1;
            @(negedge Hclk);
            check("rst_novalid", {resp_valid, Penable_s, Psel_s}, 0);
        end
        check("rst_ready_post", req_ready, 1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        Hresetn   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        Prdata_s  = '0;
        Pready_s  = '0;
        Pslverr_s = '0;
        #1;
        check("rst_ready0", req_ready, 1);
        check("rst_resp0", {resp_valid, resp_err, resp_timeout}, 0);
        check("rst_rdata0", resp_rdata, 0);
        check("rst_paddr0", Paddr_s, 0);
        check("rst_pwdata0", Pwdata_s, 0);
        check("rst_apb0", {Pwrite_s, Penable_s, Psel_s}, 0);
        repeat (2) @(negedge Hclk);
        Hresetn = 1'b1;
        @(negedge Hclk);

        xfer(4'd2, 1'b0, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
        xfer(4'd1, 1'b1, 32'h1234_5678, 3, 1'b0, 32'h0);
        xfer(4'd7, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        xfer(4'd1, 1'b0, 32'h0, 1000, 1'b0, 32'h0);
        xfer(4'd3, 1'b0, 32'h0, TIMEOUT - 1, 1'b1, 32'h0);
        xfer(4'd0, 1'b0, 32'h0, TIMEOUT - 1, 1'b0, 32'h0);
        xfer(4'd15, 1'b1, 32'hFFFF_FFFF, 0, 1'b0, 32'h0);

        for (int t = 0; t < 60; t++) begin
            logic [3:0] s;
            s = 4'($urandom_range(0, 7));
            xfer(s, 1'($urandom), $urandom, $urandom_range(0, 20),
                 1'($urandom_range(0, 3) == 0), 32'h0);
        end

        rst_mid();
        xfer(4'd2, 1'b0, 32'h0, 2, 1'b0, 32'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_slave_mux.md
# apb_slave_mux

Parametrised APB slave-side sequencer and response multiplexer for the AHB-to-APB bridge. It accepts one transfer request at a time from the bridge control logic, decodes a slave index from an address field, and drives the selected APB slave through SETUP and ACCESS phases. It then returns a registered response: read data, error and timeout flags. Up to NSLV slaves are supported, with a per-transfer wait-state timeout and an error response for unmapped indices.

## Interface
Parameters:
- NSLV, 4, number of APB slaves (1..2^SEL_W)
- DW, 32, data width
- SEL_LSB, 8, LSB of slave-index field in req_addr
- SEL_W, 4, width of slave-index field
- TIMEOUT, 16, max ACCESS cycles before forced error; 0 disables timeout

Ports:
- Hclk  in  1  clock, all state on rising edge
- Hresetn  in  1  asynchronous active-low reset
- req_valid  in  1  transfer request
- req_ready  out  1  block can accept a request
- req_addr  in  32  transfer address
- req_write  in  1  1 = write, 0 = read
- req_wdata  in  DW  write data
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  DW  read data (0 for writes and errors)
- resp_err  out  1  slave error, unmapped index or timeout
- resp_timeout  out  1  response caused by timeout
- Paddr_s  out  32  APB address to all slaves
- Pwrite_s  out  1  APB direction
- Pwdata_s  out  DW  APB write data
- Psel_s  out  NSLV  one-hot slave select
- Penable_s  out  1  APB enable
- Prdata_s  in  NSLV*DW  slave read data, slave i at [i*DW +: DW]
- Pready_s  in  NSLV  slave ready
- Pslverr_s  in  NSLV  slave error

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS and RESP.
- req_ready = (state == IDLE). It is combinational from the state register.
- All other outputs are registered.
- IDLE:
  - On req_valid, latch req_addr, req_write and req_wdata into Paddr_s, Pwrite_s and Pwdata_s.
  - Latch idx = req_addr[SEL_LSB +: SEL_W].
  - If idx < NSLV, go to SETUP.
  - Otherwise go to RESP with resp_err=1, resp_timeout=0 and resp_rdata=0. No slave is touched.
- SETUP (exactly one cycle):
  - Psel_s[idx]=1, Penable_s=0.
  - Clear the wait counter, then go to ACCESS.
- ACCESS:
  - Psel_s[idx]=1, Penable_s=1, counter += 1 per cycle.
  - If Pready_s[idx]=1, go to RESP and capture:
    - resp_err = Pslverr_s[idx];
    - resp_rdata = Prdata_s[idx] for a read, or 0 for a write or when Pslverr_s[idx]=1;
    - resp_timeout = 0.
  - Else if TIMEOUT != 0 and the counter reaches TIMEOUT, go to RESP with resp_err=1, resp_timeout=1 and resp_rdata=0.
  - Pready_s[idx] takes priority over timeout in the same cycle.
- RESP: resp_valid=1 for exactly one cycle, Psel_s=0, Penable_s=0, then return to IDLE.
- resp_rdata, resp_err and resp_timeout hold their values until the next RESP.
- Pready_s and Pslverr_s of unselected slaves, and of any slave outside ACCESS, are ignored.
- Paddr_s, Pwrite_s and Pwdata_s hold their latched values between transfers.
- The counter width is clog2(TIMEOUT+1) bits and never wraps.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, so req_ready=1;
  - resp_valid, resp_err, resp_timeout = 0;
  - resp_rdata, Paddr_s, Pwdata_s = 0;
  - Pwrite_s, Psel_s, Penable_s = 0.
- Reset mid-transfer drops Psel_s and Penable_s at once. No response is emitted.
- Let cycle 0 be the cycle in which the req_valid & req_ready handshake occurs.
- Mapped transfer, zero-wait slave:
  - SETUP is visible in cycle 1 and ACCESS in cycle 2;
  - resp_valid is high in cycle 3, so latency is 3 cycles.
- Each slave wait state adds 1 cycle.
- Unmapped index: resp_valid is high in cycle 1.
- Timeout: ACCESS lasts TIMEOUT cycles and resp_valid is high in cycle 2+TIMEOUT.
- Back-to-back: the earliest next handshake is in the cycle after resp_valid.
  - Minimum spacing is 4 cycles per mapped transfer.
  - req_valid outside IDLE is not accepted; the requester holds it.

## Test plan
- Mapped read, zero-wait:
  - Stimulus: req_addr=0x0000_0200, slave 2 Prdata=0xDEAD_BEEF, Pready high.
  - Response: Psel_s=4'b0100 in cycles 1–2, Penable_s in cycle 2, resp_valid in cycle 3 with rdata=0xDEAD_BEEF and err=0.
- Write with 3 wait states:
  - Stimulus: req_addr=0x0000_0100, wdata=0x1234_5678.
  - Response: Pwdata_s=0x1234_5678 and Pwrite_s=1 from cycle 1, ACCESS lasts 4 cycles, resp_valid in cycle 6 with rdata=0 and err=0.
- Unmapped index:
  - Stimulus: req_addr=0x0000_0700 with NSLV=4.
  - Response: Psel_s stays 0, resp_valid in cycle 1 with err=1, timeout=0, rdata=0.
- Timeout:
  - Stimulus: slave 1 never asserts Pready, TIMEOUT=16.
  - Response: resp_valid in cycle 18 with err=1, timeout=1, rdata=0.
  - Then Psel_s=0 and req_ready=1 in cycle 19.
- Slave error and simultaneous timeout:
  - Stimulus: Pready_s[3] and Pslverr_s[3] both high on ACCESS cycle 16.
  - Response: err=1, timeout=0, rdata=0 (ready wins over timeout).
- Reset mid-ACCESS:
  - Stimulus: assert Hresetn=0 asynchronously during ACCESS.
  - Response: Psel_s and Penable_s go to 0 before the next edge, no resp_valid, req_ready=1 after release.
